// File: rtl/ntt_bank_addr_gen_pkg.sv
// Shared constants, FSM encoding and lane types for the radix-16 NTT
// bank/address generator.
package ntt_pkg;

    localparam int RADIX     = 16;
    localparam int LOG_RADIX = 4;
    localparam int LANE_W    = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    typedef logic [RADIX-1:0][LANE_W-1:0] lane_arr_t;

    function automatic int stage_w(input int s);
        return (s > 1) ? $clog2(s) : 1;
    endfunction

    function automatic int j_w(input int s);
        return (s > 1) ? LOG_RADIX * (s - 1) : 1;
    endfunction

endpackage

// File: rtl/ntt_bank_addr_gen_if.sv
// Control and index bundle between the address generator and the
// downstream index delay stage.
interface ntt_bank_addr_gen_if #(
    parameter int STAGES  = 3,
    parameter int D_WIDTH = 8
);
    import ntt_pkg::*;

    localparam int SW = stage_w(STAGES);

    logic                          start;
    logic                          stall;
    logic [RADIX-1:0][D_WIDTH-1:0] ma_idx;
    logic [RADIX-1:0][D_WIDTH-1:0] bn_idx;
    logic                          ntt_enable;
    logic [SW-1:0]                 stage_o;
    logic                          last_o;
    logic                          busy;
    logic                          done;

    modport master (
        output start, stall,
        input  ma_idx, bn_idx, ntt_enable, stage_o, last_o, busy, done
    );

    modport slave (
        input  start, stall,
        output ma_idx, bn_idx, ntt_enable, stage_o, last_o, busy, done
    );

endinterface

// File: rtl/ntt_bank_addr_gen_map.sv
// Combinational (stage, group j, lane k) -> (in-bank address, bank) map.
// Lane digit is inserted at the DIF digit position; bank is the digit sum.
module ntt_bank_map
    import ntt_pkg::*;
#(
    parameter int STAGES  = 3,
    parameter int D_WIDTH = 8,
    parameter int SW      = stage_w(STAGES),
    parameter int JW      = j_w(STAGES)
) (
    input  logic [SW-1:0]      stage,
    input  logic [JW-1:0]      j,
    input  logic [3:0]         k,
    output logic [D_WIDTH-1:0] ma,
    output logic [D_WIDTH-1:0] bn
);

    localparam int IW = LOG_RADIX * STAGES;

    logic [IW-1:0] j_lo;
    logic [IW-1:0] j_hi;
    logic [IW-1:0] idx;
    logic [3:0]    bsum;
    int            p;

    always_comb begin
        j_lo = IW'(j);
        j_hi = j_lo << LOG_RADIX;
        p    = STAGES - 1 - int'(stage);
        idx  = '0;
        bsum = '0;
        // digits below p come from j as-is, digits above from j shifted up
        for (int d = 0; d < STAGES; d++) begin
            if (d < p)
                idx[4*d +: 4] = j_lo[4*d +: 4];
            else if (d == p)
                idx[4*d +: 4] = k;
            else
                idx[4*d +: 4] = j_hi[4*d +: 4];
            bsum = bsum + idx[4*d +: 4];
        end
        ma = D_WIDTH'(idx >> LOG_RADIX);
        bn = D_WIDTH'(bsum);
    end

endmodule

// File: rtl/ntt_bank_addr_gen.sv
// Radix-16 NTT address generator: walks every (stage, group) of the
// transform and registers 16 conflict-free bank/address pairs per cycle.
module ntt_bank_addr_gen
    import ntt_pkg::*;
#(
    parameter int STAGES  = 3,
    parameter int D_WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    ntt_bank_addr_gen_if.slave bus
);

    localparam int SW = stage_w(STAGES);
    localparam int JW = j_w(STAGES);
    localparam logic [SW-1:0] LAST_STG = SW'(STAGES - 1);
    localparam logic [JW-1:0] LAST_J   = JW'((RADIX ** (STAGES - 1)) - 1);

    state_t        state_q, state_d;
    logic [SW-1:0] stg_q, stg_d;
    logic [JW-1:0] j_q, j_d;
    logic          load;
    logic          en_d, last_d, done_d;

    logic [RADIX-1:0][D_WIDTH-1:0] ma_c, bn_c;
    logic [RADIX-1:0][D_WIDTH-1:0] ma_q, bn_q;
    logic [SW-1:0]                 stg_oq;
    logic                          en_q, last_q, done_q;

    for (genvar g = 0; g < RADIX; g++) begin : g_lane
        ntt_bank_map #(
            .STAGES  (STAGES),
            .D_WIDTH (D_WIDTH),
            .SW      (SW),
            .JW      (JW)
        ) u_map (
            .stage (stg_q),
            .j     (j_q),
            .k     (4'(g)),
            .ma    (ma_c[g]),
            .bn    (bn_c[g])
        );
    end

    always_comb begin
        state_d = state_q;
        stg_d   = stg_q;
        j_d     = j_q;
        load    = 1'b0;
        en_d    = 1'b0;
        last_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    stg_d   = '0;
                    j_d     = '0;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    load   = 1'b1;
                    en_d   = 1'b1;
                    last_d = (stg_q == LAST_STG) && (j_q == LAST_J);
                    if (j_q == LAST_J) begin
                        j_d = '0;
                        if (stg_q == LAST_STG)
                            state_d = FIN;
                        else
                            stg_d = stg_q + SW'(1);
                    end else begin
                        j_d = j_q + JW'(1);
                    end
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            stg_q   <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            stg_q   <= stg_d;
            j_q     <= j_d;
        end
    end

    // index outputs hold their last group while stalled or idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ma_q   <= '0;
            bn_q   <= '0;
            stg_oq <= '0;
            en_q   <= 1'b0;
            last_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            en_q   <= en_d;
            last_q <= last_d;
            done_q <= done_d;
            if (load) begin
                ma_q   <= ma_c;
                bn_q   <= bn_c;
                stg_oq <= stg_q;
            end
        end
    end

    assign bus.ma_idx     = ma_q;
    assign bus.bn_idx     = bn_q;
    assign bus.stage_o    = stg_oq;
    assign bus.ntt_enable = en_q;
    assign bus.last_o     = last_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ntt_bank_addr_gen.sv
// Directed bench for ntt_bank_addr_gen (STAGES=3, D_WIDTH=8, N=4096).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ntt_bank_addr_gen;
    import ntt_pkg::*;

    localparam int STAGES  = 3;
    localparam int D_WIDTH = 8;
    localparam int GROUPS  = 256;
    localparam int TOTAL   = 768;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    lane_arr_t h0_ma, h0_bn, h1_ma, h1_bn, h2_ma, h2_bn;

    ntt_bank_addr_gen_if #(.STAGES(STAGES), .D_WIDTH(D_WIDTH)) bus ();

    ntt_bank_addr_gen #(.STAGES(STAGES), .D_WIDTH(D_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // idx = high digits of j shifted up, lane digit at p, low digits of j
    function automatic void expect_grp(input int s, input int j,
                                       output lane_arr_t ema,
                                       output lane_arr_t ebn);
        int pw, idx;
        pw = 1 << (4 * (STAGES - 1 - s));
        for (int k = 0; k < 16; k++) begin
            idx    = (j / pw) * pw * 16 + k * pw + (j % pw);
            ema[k] = 8'(idx / 16);
            ebn[k] = 8'((idx % 16 + (idx / 16) % 16 + (idx / 256) % 16) % 16);
        end
    endfunction

    task automatic build_hand_vectors();
        for (int k = 0; k < 16; k++) begin
            h0_ma[k] = 8'(16 * k);
            h0_bn[k] = 8'(k);
            h1_ma[k] = 8'(16 + k);
            h1_bn[k] = 8'((3 + k) % 16);
            h2_ma[k] = 8'd1;
            h2_bn[k] = 8'((1 + k) % 16);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.ma_idx !== '0 || bus.bn_idx !== '0) begin
            errors++;
            $display("FAIL reset_idx ma=%h bn=%h exp 0", bus.ma_idx, bus.bn_idx);
        end
        checks++;
        if ({bus.ntt_enable, bus.stage_o, bus.last_o, bus.busy, bus.done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl en=%b stg=%0d last=%b busy=%b done=%b exp all 0",
                     bus.ntt_enable, bus.stage_o, bus.last_o, bus.busy, bus.done);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.ntt_enable !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start busy=%b en=%b exp 0 0", bus.busy, bus.ntt_enable);
        end
    endtask

    task automatic test_full_run();
        lane_arr_t   ema, ebn;
        logic [15:0] seen;
        int          cnt = 0;
        int          done_cnt = 0;
        int          s, j;
        logic        prev_last = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.ntt_enable !== 1'b0) begin
            errors++;
            $display("FAIL run_latency busy=%b en=%b exp busy=1 en=0", bus.busy, bus.ntt_enable);
        end
        for (int cyc = 0; cyc < TOTAL + 20 && done_cnt == 0; cyc++) begin
            @(negedge clk);
            if (bus.ntt_enable === 1'b1) begin
                s = cnt / GROUPS;
                j = cnt % GROUPS;
                expect_grp(s, j, ema, ebn);
                checks++;
                if (bus.stage_o !== 2'(s) || bus.ma_idx !== ema || bus.bn_idx !== ebn) begin
                    errors++;
                    $display("FAIL group s=%0d j=%0d stg=%0d ma=%h bn=%h exp ma=%h bn=%h",
                             s, j, bus.stage_o, bus.ma_idx, bus.bn_idx, ema, ebn);
                end
                seen = '0;
                for (int k = 0; k < 16; k++) seen[bus.bn_idx[k][3:0]] = 1'b1;
                checks++;
                if (seen !== 16'hffff) begin
                    errors++;
                    $display("FAIL bn_perm s=%0d j=%0d set=%h exp ffff", s, j, seen);
                end
                checks++;
                if (bus.last_o !== (cnt == TOTAL - 1)) begin
                    errors++;
                    $display("FAIL last_o cnt=%0d got=%b exp=%b", cnt, bus.last_o, cnt == TOTAL - 1);
                end
                if (cnt == 0) begin
                    checks++;
                    if (bus.ma_idx !== h0_ma || bus.bn_idx !== h0_bn) begin
                        errors++;
                        $display("FAIL s0_j0 ma=%h bn=%h exp ma=%h bn=%h",
                                 bus.ma_idx, bus.bn_idx, h0_ma, h0_bn);
                    end
                end
                if (cnt == GROUPS + 'h12) begin
                    checks++;
                    if (bus.stage_o !== 2'd1 || bus.ma_idx !== h1_ma || bus.bn_idx !== h1_bn) begin
                        errors++;
                        $display("FAIL s1_j12 stg=%0d ma=%h bn=%h exp 1 ma=%h bn=%h",
                                 bus.stage_o, bus.ma_idx, bus.bn_idx, h1_ma, h1_bn);
                    end
                end
                if (cnt == 2 * GROUPS + 1) begin
                    checks++;
                    if (bus.stage_o !== 2'd2 || bus.ma_idx !== h2_ma || bus.bn_idx !== h2_bn) begin
                        errors++;
                        $display("FAIL s2_j1 stg=%0d ma=%h bn=%h exp 2 ma=%h bn=%h",
                                 bus.stage_o, bus.ma_idx, bus.bn_idx, h2_ma, h2_bn);
                    end
                end
                cnt++;
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                checks++;
                if (!prev_last || bus.ntt_enable !== 1'b0 || cnt != TOTAL) begin
                    errors++;
                    $display("FAIL done_timing prev_last=%b en=%b cnt=%0d exp 1 0 %0d",
                             prev_last, bus.ntt_enable, cnt, TOTAL);
                end
            end
            prev_last = bus.ntt_enable && bus.last_o;
        end
        checks++;
        if (done_cnt != 1 || cnt != TOTAL) begin
            errors++;
            $display("FAIL run_count enables=%0d dones=%0d exp %0d 1", cnt, done_cnt, TOTAL);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ntt_enable !== 1'b0) begin
            errors++;
            $display("FAIL after_run busy=%b done=%b en=%b exp 0 0 0",
                     bus.busy, bus.done, bus.ntt_enable);
        end
    endtask

    task automatic test_stall_run();
        lane_arr_t  ema, ebn, hold_ma, hold_bn;
        logic [1:0] hold_stg = '0;
        int         cnt = 0;
        int         done_cnt = 0;
        int         s, j;
        logic       prev_stall = 1'b0;
        logic       late_en = 1'b0;
        hold_ma = '0;
        hold_bn = '0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 4000 && done_cnt == 0; cyc++) begin
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (bus.ntt_enable !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_en cyc=%0d en=%b exp 0", cyc, bus.ntt_enable);
                end
            end
            if (bus.ntt_enable === 1'b1) begin
                s = cnt / GROUPS;
                j = cnt % GROUPS;
                expect_grp(s, j, ema, ebn);
                checks++;
                if (bus.stage_o !== 2'(s) || bus.ma_idx !== ema || bus.bn_idx !== ebn) begin
                    errors++;
                    $display("FAIL stall_seq s=%0d j=%0d stg=%0d ma=%h exp ma=%h",
                             s, j, bus.stage_o, bus.ma_idx, ema);
                end
                hold_ma  = bus.ma_idx;
                hold_bn  = bus.bn_idx;
                hold_stg = bus.stage_o;
                cnt++;
            end else if (cnt > 0) begin
                checks++;
                if (bus.ma_idx !== hold_ma || bus.bn_idx !== hold_bn || bus.stage_o !== hold_stg) begin
                    errors++;
                    $display("FAIL hold cyc=%0d ma=%h stg=%0d exp ma=%h stg=%0d",
                             cyc, bus.ma_idx, bus.stage_o, hold_ma, hold_stg);
                end
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                checks++;
                if (cnt != TOTAL) begin
                    errors++;
                    $display("FAIL stall_count enables=%0d exp %0d", cnt, TOTAL);
                end
            end
            bus.stall  = ($urandom_range(0, 99) < 30);
            bus.start  = bus.busy && ($urandom_range(0, 99) < 10);
            prev_stall = bus.stall;
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL stall_done dones=%0d exp 1", done_cnt);
        end
        repeat (6) begin
            @(negedge clk);
            if (bus.ntt_enable !== 1'b0 || bus.busy !== 1'b0) late_en = 1'b1;
        end
        checks++;
        if (late_en) begin
            errors++;
            $display("FAIL no_restart en/busy seen after done, exp idle");
        end
    endtask

    task automatic test_mid_reset();
        logic bad = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.ma_idx !== '0 || bus.bn_idx !== '0 ||
            {bus.ntt_enable, bus.stage_o, bus.last_o, bus.busy, bus.done} !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset ma=%h en=%b busy=%b done=%b exp all 0",
                     bus.ma_idx, bus.ntt_enable, bus.busy, bus.done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.ntt_enable !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL mid_reset_quiet done/busy/en nonzero after reset, exp 0");
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ntt_enable !== 1'b1 || bus.stage_o !== 2'd0 ||
            bus.ma_idx !== h0_ma || bus.bn_idx !== h0_bn) begin
            errors++;
            $display("FAIL restart en=%b stg=%0d ma=%h bn=%h exp 1 0 ma=%h bn=%h",
                     bus.ntt_enable, bus.stage_o, bus.ma_idx, bus.bn_idx, h0_ma, h0_bn);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        build_hand_vectors();
        test_reset();
        test_full_run();
        test_stall_run();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
